deser_word_sched: RTL and testbench

DESER_WORD_SCHED -- requirements
Module: deser_word_sched

---
 rtl/deser_word_sched_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/deser_word_sched.sv | 90 +++++++++
 tb/tb_deser_word_sched.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/deser_word_sched_pkg.sv
// deser_word_sched_pkg: shared shift commands and default sizes
package deser_word_sched_pkg;
  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_1B = 2'b01;
  localparam logic [1:0] CTRL_2B = 2'b11;
  localparam int NUM_CH_DEF = 4;
  localparam int WORD_W_DEF = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);
  // scan from the far end so the last hit is the nearest one to ptr
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_idx = IW'((int'(ptr) + k) % N);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/deser_word_sched.sv
// deser_word_sched: per-channel holding slots merged round-robin into one output stream
module deser_word_sched
  import deser_word_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      dual_rate,
  output logic [1:0]                shift_ctrl,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH*WORD_W-1:0]  ch_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_data,
  output logic [$clog2(NUM_CH)-1:0] out_chan,
  output logic [NUM_CH-1:0]         ovf,
  input  logic                      ovf_clr
);
  localparam int CW = $clog2(NUM_CH);
  logic [WORD_W-1:0] slot_q [NUM_CH];
  logic [WORD_W-1:0] slot_d [NUM_CH];
  logic [NUM_CH-1:0] full_q, full_d, ovf_q, ovf_d;
  logic [CW-1:0] rr_q, rr_d, out_chan_q, out_chan_d, gnt_idx;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [1:0] shift_q, shift_d;
  logic out_valid_q, out_valid_d, gnt_any, load_out, stall;

  rr_arbiter #(.N(NUM_CH), .IW(CW)) u_arb (
    .req(full_q),
    .ptr(rr_q),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );

  assign load_out = (!out_valid_q || out_ready) && gnt_any;
  assign stall = (&full_q) && out_valid_q && !out_ready;

  // slot fill/drain, overflow tracking, output register and shift command
  always_comb begin
    slot_d = slot_q;
    full_d = full_q;
    ovf_d = ovf_clr ? '0 : ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_out && gnt_idx == CW'(i)) full_d[i] = 1'b0;
      if (ch_valid[i]) begin
        if (!full_q[i] || (load_out && gnt_idx == CW'(i))) begin
          slot_d[i] = ch_data[i*WORD_W +: WORD_W];
          full_d[i] = 1'b1;
        end else ovf_d[i] = 1'b1;
      end
    end
    out_valid_d = load_out ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d = load_out ? slot_q[gnt_idx] : out_data_q;
    out_chan_d = load_out ? gnt_idx : out_chan_q;
    rr_d = !load_out ? rr_q : (gnt_idx == CW'(NUM_CH - 1) ? '0 : gnt_idx + 1'b1);
    shift_d = (stall || !enable) ? CTRL_HOLD : (dual_rate ? CTRL_2B : CTRL_1B);
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '{default: '0};
      full_q <= '0;
      ovf_q <= '0;
      rr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      shift_q <= CTRL_HOLD;
    end else begin
      slot_q <= slot_d;
      full_q <= full_d;
      ovf_q <= ovf_d;
      rr_q <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      shift_q <= shift_d;
    end
  end

  assign shift_ctrl = shift_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_deser_word_sched.sv
// tb_deser_word_sched: directed stimulus with a queue scoreboard checked by a monitor
module tb_deser_word_sched;
  logic clk = 1'b0;
  logic rst, enable, dual_rate, out_ready, ovf_clr, out_valid;
  logic [1:0] shift_ctrl, out_chan;
  logic [3:0] ch_valid, ovf;
  logic [63:0] ch_data;
  logic [15:0] out_data;
  logic [17:0] exp_q [$];
  int total = 0;
  int bad = 0;

  deser_word_sched dut (
    .clk(clk), .rst(rst), .enable(enable), .dual_rate(dual_rate),
    .shift_ctrl(shift_ctrl), .ch_valid(ch_valid), .ch_data(ch_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input int i, input logic [15:0] w);
    ch_data[i*16 +: 16] = w;
  endtask

  task automatic push(input logic [1:0] c, input logic [15:0] w);
    exp_q.push_back({c, w});
  endtask

  // monitor: every accepted word must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got chan=%0d data=%h want none", out_chan, out_data);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({out_chan, out_data} !== e) begin
          bad++;
          $display("FAIL word: got chan=%0d data=%h want chan=%0d data=%h",
                   out_chan, out_data, e[17:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; dual_rate = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
    ch_valid = '0; ch_data = '0;
    step(); enable = 1'b1; step();
    chk("rst_shift", 32'(shift_ctrl), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_chan", 32'(out_chan), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b0; step();
    chk("shift_2b", 32'(shift_ctrl), 3);
    dual_rate = 1'b0; step();
    chk("shift_1b", 32'(shift_ctrl), 1);
    enable = 1'b0; step();
    chk("shift_hold", 32'(shift_ctrl), 0);
    enable = 1'b1; dual_rate = 1'b1; step();
    // four channels at once drain in channel order from rr_ptr=0
    ch_valid = 4'b1111;
    setw(0, 16'h1111); setw(1, 16'h2222); setw(2, 16'h3333); setw(3, 16'h4444);
    for (int i = 0; i < 4; i++) push(2'(i), 16'h1111 * 16'(i + 1));
    step(); ch_valid = '0;
    chk("lat_not_yet", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("burst_valid", 32'(out_valid), 1);
      chk("burst_chan", 32'(out_chan), i);
    end
    step();
    chk("burst_idle", 32'(out_valid), 0);
    // rr_ptr back at 0: ch0 must beat ch3
    ch_valid = 4'b1001; setw(0, 16'h0F0F); setw(3, 16'hF0F0);
    push(0, 16'h0F0F); push(3, 16'hF0F0);
    step(); ch_valid = '0; step(); step(); step();
    // single word latency
    ch_valid = 4'b0001; setw(0, 16'hA5A5); push(0, 16'hA5A5);
    step(); ch_valid = '0;
    chk("lat1_valid", 32'(out_valid), 0);
    step();
    chk("lat2_valid", 32'(out_valid), 1);
    chk("lat2_data", 32'(out_data), 32'hA5A5);
    step();
    chk("drop_valid", 32'(out_valid), 0);
    // overflow on ch2 with the output register blocked
    out_ready = 1'b0;
    ch_valid = 4'b0001; setw(0, 16'h0123); push(0, 16'h0123);
    step(); ch_valid = '0; step();
    ch_valid = 4'b0110; setw(1, 16'h1234); setw(2, 16'hBEEF);
    push(1, 16'h1234); push(2, 16'hBEEF);
    step(); ch_valid = 4'b0100; setw(2, 16'hDEAD);
    step(); ch_valid = '0;
    chk("ovf2", 32'(ovf), 32'h4);
    chk("hold_chan", 32'(out_chan), 0);
    ovf_clr = 1'b1; ch_valid = 4'b0010; setw(1, 16'h5555);
    step(); ch_valid = '0;
    chk("ovf_clr_race", 32'(ovf), 32'h2);
    step(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);
    chk("hold_data", 32'(out_data), 32'h0123);
    out_ready = 1'b1;
    step(); step(); step(); step();
    chk("ovf_drain_idle", 32'(out_valid), 0);
    // stall: all slots full and output blocked, rr_ptr=3
    out_ready = 1'b0;
    ch_valid = 4'b1111;
    setw(0, 16'hC000); setw(1, 16'hC001); setw(2, 16'hC002); setw(3, 16'hC003);
    push(3, 16'hC003); push(0, 16'hC000); push(1, 16'hC001); push(2, 16'hC002);
    step(); ch_valid = 4'b1000; setw(3, 16'hC013); push(3, 16'hC013);
    step(); ch_valid = '0;
    chk("pre_stall_shift", 32'(shift_ctrl), 3);
    step();
    chk("stall_shift", 32'(shift_ctrl), 0);
    step();
    chk("stall_shift2", 32'(shift_ctrl), 0);
    out_ready = 1'b1; step();
    chk("unstall_shift", 32'(shift_ctrl), 3);
    for (int i = 0; i < 5; i++) step();
    chk("stall_idle", 32'(out_valid), 0);
    // reset mid-transfer discards everything
    out_ready = 1'b0; ch_valid = 4'b1111;
    step(); ch_valid = '0; step();
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1; step(); rst = 1'b0; out_ready = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_shift", 32'(shift_ctrl), 0);
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_idle", 32'(out_valid), 0);
    // rr_ptr reset to 0
    ch_valid = 4'b1001; setw(0, 16'h7000); setw(3, 16'h7003);
    push(0, 16'h7000); push(3, 16'h7003);
    step(); ch_valid = '0;
    for (int i = 0; i < 4; i++) step();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
